// File: rtl/soc_system_saida_pkg.sv
// ---------------------------------------------------------------------------
// soc_system_saida_pkg
// Shared definitions for the HPS -> coprocessor command port:
//   - register word addresses on the lightweight-bridge slave
//   - STATUS / CTRL bit positions and the STATUS level field offset
//   - a helper that packs the STATUS word
// ---------------------------------------------------------------------------
package soc_system_saida_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA   = 2'd0,
        ADDR_STATUS = 2'd1,
        ADDR_CTRL   = 2'd2,
        ADDR_RSVD   = 2'd3
    } reg_addr_e;

    // STATUS register layout
    localparam int STATUS_EMPTY_BIT = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_OVF_BIT   = 2;
    localparam int STATUS_EN_BIT    = 3;
    localparam int STATUS_LVL_OFS   = 8;

    // CTRL register layout
    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_FLUSH_BIT   = 1;
    localparam int CTRL_CLR_OVF_BIT = 2;

    // Level is passed zero-extended to 8 bits; FIFO depths up to 255 fit.
    function automatic logic [31:0] pack_status(input logic       empty,
                                                input logic       full,
                                                input logic       overflow,
                                                input logic       enable,
                                                input logic [7:0] level);
        logic [31:0] s;
        s = '0;
        s[STATUS_EMPTY_BIT]        = empty;
        s[STATUS_FULL_BIT]         = full;
        s[STATUS_OVF_BIT]          = overflow;
        s[STATUS_EN_BIT]           = enable;
        s[STATUS_LVL_OFS +: 8]     = level;
        return s;
    endfunction

endpackage

// File: rtl/soc_system_saida_cmd_if.sv
// ---------------------------------------------------------------------------
// soc_system_saida_cmd_if
// Bundles the Avalon-MM slave side (address/chipselect/write_n/writedata/
// readdata) and the command stream side (out_data/out_valid/out_ready).
//   slave  modport : the command-port block
//   master modport : whoever drives the bus and consumes the stream
// ---------------------------------------------------------------------------
interface soc_system_saida_cmd_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  address, chipselect, write_n, writedata, out_ready,
        output readdata, out_data, out_valid
    );

    modport master (
        output address, chipselect, write_n, writedata, out_ready,
        input  readdata, out_data, out_valid
    );
endinterface

// File: rtl/soc_system_saida_fifo.sv
// ---------------------------------------------------------------------------
// soc_system_saida_fifo
// Synchronous FIFO holding command words.
//   clk, reset_n : clock, async active-low reset (pointers/level only)
//   push, din    : write request and word
//   pop          : read request (advances head on the edge)
//   flush        : empties the FIFO; overrides push and pop in that cycle
//   dout         : head word, combinational, 0 when empty
//   level        : occupancy 0..DEPTH
//   full, empty  : occupancy flags
// A push while full is accepted only when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module soc_system_saida_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int LVL_W  = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // NOTE: storage has no reset; empty entries are never observed because
    // dout is forced to 0 when level is 0, so a reset would only cost area.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/soc_system_saida_cmd.sv
// ---------------------------------------------------------------------------
// soc_system_saida_cmd
// Avalon-MM write-side command port toward the coprocessor. The HPS writes
// command words to DATA; they are queued and presented on a valid/ready
// stream once CTRL.enable is set.
//   clk, reset_n : system clock, async active-low reset
//   bus (slave)  : address/chipselect/write_n/writedata -> readdata (latency 1)
//                  out_data/out_valid -> out_ready command stream
// Registers: 0 DATA (W push), 1 STATUS (R), 2 CTRL (R/W), 3 reserved.
// ---------------------------------------------------------------------------
module soc_system_saida_cmd
    import soc_system_saida_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    soc_system_saida_cmd_if.slave  bus
);
    reg_addr_e         addr;
    logic              wr;
    logic              data_wr;
    logic              ctrl_wr;
    logic              flush;
    logic              clr_ovf;
    logic              ovf_set;
    logic              pop;
    logic              enable;
    logic              overflow;
    logic [DATA_W-1:0] fifo_dout;
    logic [LVL_W-1:0]  fifo_level;
    logic              fifo_full;
    logic              fifo_empty;
    logic [31:0]       rd_mux;

    assign addr    = reg_addr_e'(bus.address);
    assign wr      = bus.chipselect & ~bus.write_n;
    assign data_wr = wr & (addr == ADDR_DATA);
    assign ctrl_wr = wr & (addr == ADDR_CTRL);
    assign flush   = ctrl_wr & bus.writedata[CTRL_FLUSH_BIT];
    assign clr_ovf = ctrl_wr & bus.writedata[CTRL_CLR_OVF_BIT];

    // Stream side: head word is only offered while enabled.
    assign bus.out_valid = enable & ~fifo_empty;
    assign bus.out_data  = fifo_dout;
    assign pop           = bus.out_valid & bus.out_ready;

    // A word is dropped only when full with no pop to make room; a push that
    // coincides with a flush is discarded silently.
    assign ovf_set = data_wr & fifo_full & ~pop & ~flush;

    soc_system_saida_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .LVL_W  (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (data_wr),
        .pop     (pop),
        .flush   (flush),
        .din     (bus.writedata[DATA_W-1:0]),
        .dout    (fifo_dout),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (ctrl_wr) enable <= bus.writedata[CTRL_EN_BIT];
            // Set has priority over a same-cycle clear.
            if (ovf_set)      overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    // NOTE: rd_mux gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_STATUS: rd_mux = pack_status(fifo_empty, fifo_full, overflow,
                                              enable, 8'(fifo_level));
            ADDR_CTRL:   rd_mux = {31'b0, enable};
            default:     rd_mux = '0;
        endcase
    end

    // Read latency 1 with no read strobe: the mux is registered every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.readdata <= '0;
        else          bus.readdata <= rd_mux;
    end

endmodule

// File: tb/tb_soc_system_saida_cmd.sv
// ---------------------------------------------------------------------------
// tb_soc_system_saida_cmd
// Directed self-checking bench for soc_system_saida_cmd. Inputs change on
// the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_soc_system_saida_cmd;
    import soc_system_saida_pkg::*;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    soc_system_saida_cmd_if #(.DATA_W(32)) bus ();

    soc_system_saida_cmd #(
        .DATA_W     (32),
        .FIFO_DEPTH (4),
        .LVL_W      (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input reg_addr_e a, input logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_read(input reg_addr_e a, output logic [31:0] d);
        @(negedge clk);
        bus.address = a;
        @(negedge clk);
        d = bus.readdata;
    endtask

    task automatic check_reg(input string tag, input reg_addr_e a, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(a, v);
        check(tag, v, exp);
    endtask

    // Pops one word per cycle and compares each head word against exp.
    task automatic drain(input string tag, input logic [31:0] exp [4]);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
            check({tag, "_data"}, bus.out_data, exp[i]);
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    logic [31:0] got [$];
    logic [31:0] exp4 [4];

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        reset_n        = 1'b0;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        bus.out_ready  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_data", bus.out_data, 32'd0);
        check("rst_readdata", bus.readdata, 32'd0);
        reset_n = 1'b1;
        check_reg("status_after_reset", ADDR_STATUS, 32'h0000_0001);
        check("valid_after_reset", {31'b0, bus.out_valid}, 32'd0);

        // Single word through the stream
        bus_write(ADDR_DATA, 32'h0000_00A5);
        bus_write(ADDR_CTRL, 32'h1);
        check("single_valid", {31'b0, bus.out_valid}, 32'd1);
        check("single_data", bus.out_data, 32'h0000_00A5);
        check_reg("single_status", ADDR_STATUS, 32'h0000_0108);
        check_reg("ctrl_readback", ADDR_CTRL, 32'h1);
        check_reg("data_readback", ADDR_DATA, 32'h0);
        check_reg("rsvd_readback", ADDR_RSVD, 32'h0);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("single_popped_valid", {31'b0, bus.out_valid}, 32'd0);
        check_reg("single_popped_status", ADDR_STATUS, 32'h0000_0009);

        // Overflow with stream disabled
        bus_write(ADDR_CTRL, 32'h0);
        for (int i = 1; i <= 5; i++) bus_write(ADDR_DATA, 32'(i));
        check("disabled_valid", {31'b0, bus.out_valid}, 32'd0);
        check_reg("ovf_status", ADDR_STATUS, 32'h0000_0406);
        bus_write(ADDR_CTRL, 32'h1);
        exp4 = '{32'd1, 32'd2, 32'd3, 32'd4};
        drain("ovf_drain", exp4);
        check("ovf_drained_valid", {31'b0, bus.out_valid}, 32'd0);
        check_reg("ovf_sticky", ADDR_STATUS, 32'h0000_000D);
        bus_write(ADDR_CTRL, 32'h5);
        check_reg("ovf_cleared", ADDR_STATUS, 32'h0000_0009);

        // Push into full FIFO with simultaneous pop
        bus_write(ADDR_DATA, 32'h11);
        bus_write(ADDR_DATA, 32'h22);
        bus_write(ADDR_DATA, 32'h33);
        bus_write(ADDR_DATA, 32'h44);
        check_reg("full_status", ADDR_STATUS, 32'h0000_040A);
        @(negedge clk);
        bus.address    = ADDR_DATA;
        bus.writedata  = 32'h77;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.out_ready  = 1'b1;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.out_ready  = 1'b0;
        check_reg("push_pop_full_status", ADDR_STATUS, 32'h0000_040A);
        exp4 = '{32'h22, 32'h33, 32'h44, 32'h77};
        drain("push_pop_drain", exp4);
        check_reg("push_pop_empty", ADDR_STATUS, 32'h0000_0009);

        // Flush with a simultaneous pop request
        bus_write(ADDR_DATA, 32'hAA);
        bus_write(ADDR_DATA, 32'hBB);
        @(negedge clk);
        bus.address    = ADDR_CTRL;
        bus.writedata  = 32'h3;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.out_ready  = 1'b1;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.out_ready  = 1'b0;
        check("flush_valid", {31'b0, bus.out_valid}, 32'd0);
        check("flush_data", bus.out_data, 32'd0);
        check_reg("flush_status", ADDR_STATUS, 32'h0000_0009);

        // Streaming across pointer wrap with out_ready toggling
        got.delete();
        fork
            begin
                for (int i = 0; i < 10; i++) bus_write(ADDR_DATA, 32'h100 + 32'(i));
            end
            begin
                for (int c = 0; c < 80 && got.size() < 10; c++) begin
                    @(negedge clk);
                    bus.out_ready = ~bus.out_ready;
                    if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
                end
                @(negedge clk);
                bus.out_ready = 1'b0;
            end
        join
        check("stream_count", 32'(got.size()), 32'd10);
        for (int i = 0; i < got.size(); i++) begin
            check($sformatf("stream_word%0d", i), got[i], 32'h100 + 32'(i));
        end
        check_reg("stream_status", ADDR_STATUS, 32'h0000_0009);

        // Asynchronous reset in the middle of traffic
        bus_write(ADDR_DATA, 32'hC1);
        bus_write(ADDR_DATA, 32'hC2);
        check("pre_reset_valid", {31'b0, bus.out_valid}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_valid", {31'b0, bus.out_valid}, 32'd0);
        check("async_reset_data", bus.out_data, 32'd0);
        check("async_reset_readdata", bus.readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        check_reg("post_reset_status", ADDR_STATUS, 32'h0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
